// File: rtl/alu_pkg.sv
// Shared ALU control definitions: operation codes, ALUOp classes, Funct7 patterns
// and the M-op sequencer state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_BNE  = 4'b1010,
    OP_SLT  = 4'b1100,
    OP_BGE  = 4'b1101,
    OP_SLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JMP   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'b00,
    MD_MUL_WAIT = 2'b01,
    MD_DIV_WAIT = 2'b10
  } md_state_e;

  // Funct3 to operation for the plain (Funct7 = 0000000) arithmetic group.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/Funct3/Funct7 into the ALU operation code,
// an unqualified illegal flag and an M-op indication.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic       is_imm,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output alu_op_e    op,
  output logic       illegal,
  output logic       is_mop
);

  alu_op_e op_raw;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    op_raw  = OP_AND;
    illegal = 1'b0;
    is_mop  = 1'b0;
    case (alu_op)
      ALUOP_MEM: op_raw = OP_ADD;
      ALUOP_JMP: op_raw = OP_AND;
      ALUOP_BR: begin
        case (funct3)
          3'b000:  op_raw = OP_BEQ;
          3'b001:  op_raw = OP_BNE;
          3'b100:  op_raw = OP_SLT;
          3'b101:  op_raw = OP_BGE;
          3'b110:  op_raw = OP_SLTU;
          3'b111:  op_raw = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        if (is_imm) begin
          // Immediate bits live in Funct7 except for the shift-amount forms.
          op_raw = base_op(funct3);
          if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
          if (funct3 == 3'b101) begin
            if (funct7 == F7_ALT)       op_raw  = OP_SRA;
            else if (funct7 != F7_BASE) illegal = 1'b1;
          end
        end else begin
          case (funct7)
            F7_BASE: op_raw = base_op(funct3);
            F7_ALT: begin
              if (funct3 == 3'b000)      op_raw  = OP_SUB;
              else if (funct3 == 3'b101) op_raw  = OP_SRA;
              else                       illegal = 1'b1;
            end
            F7_MULDIV: begin
              if (ENABLE_M) is_mop  = 1'b1;
              else          illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
    endcase
  end

  assign op = illegal ? OP_AND : op_raw;

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control: combinational operation decode plus an FSM that issues
// RV32M ops to an external multi-cycle unit and stalls the pipeline until done.
module alu_control_seq
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Valid,
  input  logic       Flush,
  input  logic [1:0] ALUOp,
  input  logic       IsImm,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       MdDone,
  output logic [3:0] Operation,
  output logic       MdStart,
  output logic [2:0] MdFunct3,
  output logic       MdAbort,
  output logic       MdSel,
  output logic       Stall,
  output logic       Illegal
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  alu_op_e          dec_op;
  logic             dec_illegal;
  logic             dec_mop;
  logic             mop;
  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  alu_op_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .alu_op  (ALUOp),
    .is_imm  (IsImm),
    .funct7  (Funct7),
    .funct3  (Funct3),
    .op      (dec_op),
    .illegal (dec_illegal),
    .is_mop  (dec_mop)
  );

  assign Operation = dec_op;
  assign Illegal   = Valid & dec_illegal;
  assign mop       = Valid & dec_mop;
  assign MdFunct3  = mop ? Funct3 : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    MdStart   = 1'b0;
    MdAbort   = 1'b0;
    MdSel     = 1'b0;
    Stall     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mop && !Flush) begin
          MdStart = 1'b1;
          Stall   = 1'b1;
          if (!Funct3[2]) begin
            state_nxt = MD_MUL_WAIT;
            cnt_nxt   = CNT_W'(MUL_LAT - 1);
          end else begin
            state_nxt = MD_DIV_WAIT;
          end
        end
      end
      MD_MUL_WAIT: begin
        if (Flush) begin
          MdAbort   = 1'b1;
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          Stall   = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          MdSel     = 1'b1;
          state_nxt = MD_IDLE;
        end
      end
      MD_DIV_WAIT: begin
        // Flush takes priority over a coincident MdDone.
        if (Flush) begin
          MdAbort   = 1'b1;
          state_nxt = MD_IDLE;
        end else if (MdDone) begin
          MdSel     = 1'b1;
          state_nxt = MD_IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: the driver queues the expected outputs
// of each cycle, a negedge monitor pops and compares them against the DUT.
module tb_alu_control_seq;
  import alu_pkg::*;

  localparam logic [11:0] ALL  = 12'hFFF;
  localparam logic [11:0] NOOP = 12'h0FF;
  localparam logic [11:0] NOF3 = 12'hFF8;

  typedef struct {
    int          which;
    string       name;
    logic [11:0] exp;
    logic [11:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, valid, valid1, flush, is_imm, md_done;
  logic [1:0] alu_op;
  logic [6:0] f7;
  logic [2:0] f3;

  logic [3:0] op0, op1;
  logic [2:0] mf0, mf1;
  logic       start0, abort0, sel0, stall0, ill0;
  logic       start1, abort1, sel1, stall1, ill1;
  logic [11:0] got0, got1;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.ENABLE_M(1'b1), .MUL_LAT(3)) dut0 (
    .clk(clk), .reset(reset), .Valid(valid), .Flush(flush), .ALUOp(alu_op),
    .IsImm(is_imm), .Funct7(f7), .Funct3(f3), .MdDone(md_done),
    .Operation(op0), .MdStart(start0), .MdFunct3(mf0), .MdAbort(abort0),
    .MdSel(sel0), .Stall(stall0), .Illegal(ill0)
  );

  alu_control_seq #(.ENABLE_M(1'b0), .MUL_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .Valid(valid1), .Flush(flush), .ALUOp(alu_op),
    .IsImm(is_imm), .Funct7(f7), .Funct3(f3), .MdDone(md_done),
    .Operation(op1), .MdStart(start1), .MdFunct3(mf1), .MdAbort(abort1),
    .MdSel(sel1), .Stall(stall1), .Illegal(ill1)
  );

  assign got0 = {op0, ill0, stall0, start0, sel0, abort0, mf0};
  assign got1 = {op1, ill1, stall1, start1, sel1, abort1, mf1};

  function automatic logic [11:0] pk(input logic [3:0] op, input logic ill, input logic st,
                                     input logic sta, input logic sel, input logic ab,
                                     input logic [2:0] mf);
    return {op, ill, st, sta, sel, ab, mf};
  endfunction

  task automatic drive(input logic v, input logic fl, input logic [1:0] aop, input logic imm,
                       input logic [6:0] fn7, input logic [2:0] fn3, input logic done);
    valid   = v;
    flush   = fl;
    alu_op  = aop;
    is_imm  = imm;
    f7      = fn7;
    f3      = fn3;
    md_done = done;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic check(input string name, input int which, input logic [11:0] e,
                       input logic [11:0] m);
    exp_t r;
    r.which = which;
    r.name  = name;
    r.exp   = e;
    r.mask  = m;
    sb.push_back(r);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t r;
      logic [11:0] g;
      r = sb.pop_front();
      g = (r.which == 0) ? got0 : got1;
      total++;
      if (((g ^ r.exp) & r.mask) !== 12'h000) begin
        bad++;
        $display("FAIL %s: got=%b expected=%b care=%b", r.name, g, r.exp, r.mask);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    valid1 = 1'b0;
    drive(1'b0, 1'b0, ALUOP_MEM, 1'b0, F7_BASE, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("reset_state", 0, pk(OP_ADD, 0, 0, 0, 0, 0, 3'b000), ALL);
    reset = 1'b0;

    // Decode
    drive(1, 0, ALUOP_ARITH, 1, F7_ALT,    3'b000, 0); check("addi_f7alt",  0, pk(OP_ADD,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_ALT,    3'b000, 0); check("sub",         0, pk(OP_SUB,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_MULDIV, 3'b000, 0); check("addi_f7m",    0, pk(OP_ADD,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_BR,    0, F7_BASE,   3'b111, 0); check("bgeu",        0, pk(OP_BGEU, 0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_BR,    0, F7_BASE,   3'b110, 0); check("bltu",        0, pk(OP_SLTU, 0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_BR,    0, F7_BASE,   3'b001, 0); check("bne",         0, pk(OP_BNE,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_BR,    0, F7_BASE,   3'b010, 0); check("br_010_ill",  0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_BR,    0, F7_BASE,   3'b011, 0); check("br_011_ill",  0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_ALT,    3'b101, 0); check("srai",        0, pk(OP_SRA,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_BASE,   3'b101, 0); check("srli",        0, pk(OP_SRL,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_MULDIV, 3'b101, 0); check("shri_ill",    0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_ALT,    3'b001, 0); check("slli_ill",    0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_BASE,   3'b001, 0); check("slli",        0, pk(OP_SLL,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_ALT,    3'b100, 0); check("r_alt_ill",   0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, 7'b0000010,3'b000, 0); check("r_f7_ill",    0, pk(OP_AND,  1,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_BASE,   3'b011, 0); check("sltu",        0, pk(OP_SLTU, 0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 1, F7_BASE,   3'b010, 0); check("slti",        0, pk(OP_SLT,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_BASE,   3'b100, 0); check("xor",         0, pk(OP_XOR,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_BASE,   3'b110, 0); check("or",          0, pk(OP_OR,   0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_ALT,    3'b101, 0); check("sra",         0, pk(OP_SRA,  0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_JMP,   0, F7_BASE,   3'b000, 0); check("jal",         0, pk(OP_AND,  0,0,0,0,0,0), ALL);
    drive(0, 0, ALUOP_BR,    0, F7_BASE,   3'b011, 0); check("ill_novalid", 0, pk(OP_AND,  0,0,0,0,0,0), NOOP);

    // MUL with MdDone injected mid-sequence, then a back-to-back MULH
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 0); check("mul_t0",    0, pk(0,0,1,1,0,0,3'b000), NOOP);
    check("mul_t1", 0, pk(0,0,1,0,0,0,3'b000), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 1); check("mul_t2_done", 0, pk(0,0,1,0,0,0,3'b000), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 0); check("mul_t3",    0, pk(0,0,0,0,1,0,3'b000), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b001, 0); check("mulh_t0",   0, pk(0,0,1,1,0,0,3'b001), NOOP);
    check("mulh_t1", 0, pk(0,0,1,0,0,0,3'b001), NOOP);
    check("mulh_t2", 0, pk(0,0,1,0,0,0,3'b001), NOOP);
    check("mulh_t3", 0, pk(0,0,0,0,1,0,3'b001), NOOP);
    drive(0, 0, ALUOP_MEM,   0, F7_BASE,   3'b000, 0); check("mul_idle",  0, pk(OP_ADD,0,0,0,0,0,0), ALL);

    // DIVU completing on MdDone ten cycles after start
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b101, 0); check("divu_t0",   0, pk(0,0,1,1,0,0,3'b101), NOOP);
    for (int i = 1; i < 10; i++) check("divu_wait", 0, pk(0,0,1,0,0,0,3'b101), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b101, 1); check("divu_done", 0, pk(0,0,0,0,1,0,3'b101), NOOP);
    drive(0, 0, ALUOP_MEM,   0, F7_BASE,   3'b000, 1); check("done_idle", 0, pk(OP_ADD,0,0,0,0,0,0), ALL);

    // Flush in IDLE, during DIV_WAIT (with coincident MdDone) and during MUL_WAIT
    drive(1, 1, ALUOP_ARITH, 0, F7_MULDIV, 3'b100, 0); check("flush_idle", 0, pk(0,0,0,0,0,0,3'b100), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b100, 0); check("div_t0",     0, pk(0,0,1,1,0,0,3'b100), NOOP);
    check("div_t1", 0, pk(0,0,1,0,0,0,3'b100), NOOP);
    drive(1, 1, ALUOP_ARITH, 0, F7_MULDIV, 3'b100, 1); check("div_flush",  0, pk(0,0,0,0,0,1,3'b100), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 0); check("mul_after_flush", 0, pk(0,0,1,1,0,0,3'b000), NOOP);
    drive(1, 1, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 0); check("mul_flush",  0, pk(0,0,0,0,0,1,3'b000), NOOP);
    drive(0, 0, ALUOP_MEM,   0, F7_BASE,   3'b000, 0); check("flush_idle2",0, pk(OP_ADD,0,0,0,0,0,0), ALL);

    // Asynchronous reset while in DIV_WAIT
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b110, 0); check("rem_t0", 0, pk(0,0,1,1,0,0,3'b110), NOOP);
    check("rem_t1", 0, pk(0,0,1,0,0,0,3'b110), NOOP);
    reset = 1'b1;
    drive(0, 0, ALUOP_MEM,   0, F7_BASE,   3'b000, 0); check("reset_async", 0, pk(OP_ADD,0,0,0,0,0,0), ALL);
    reset = 1'b0;
    check("post_reset", 0, pk(OP_ADD,0,0,0,0,0,0), ALL);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b110, 0); check("rem_restart", 0, pk(0,0,1,1,0,0,3'b110), NOOP);
    drive(1, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b110, 1); check("rem_done",    0, pk(0,0,0,0,1,0,3'b110), NOOP);
    drive(0, 0, ALUOP_MEM,   0, F7_BASE,   3'b000, 0); check("rem_idle",    0, pk(OP_ADD,0,0,0,0,0,0), ALL);

    // ENABLE_M=0 instance: M-ops are illegal and never sequenced
    drive(0, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b000, 0);
    valid1 = 1'b1;
    check("nom_mul",      1, pk(OP_AND,1,0,0,0,0,0), NOF3);
    check("nom_mul_hold", 1, pk(OP_AND,1,0,0,0,0,0), NOF3);
    drive(0, 0, ALUOP_ARITH, 0, F7_MULDIV, 3'b101, 1); check("nom_div", 1, pk(OP_AND,1,0,0,0,0,0), NOF3);
    drive(0, 0, ALUOP_ARITH, 0, F7_BASE,   3'b000, 0); check("nom_add", 1, pk(OP_ADD,0,0,0,0,0,0), ALL);
    valid1 = 1'b0;

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
